// File: rtl/median_lb_pkg.sv
// Shared parameters, state type and bit-mask helper for the median filter line-buffer controller.
// One RAM word holds one column of the last SLOTS rows, DW bits per row slot.
package median_lb_pkg;

  localparam int DW        = 9;
  localparam int SLOTS     = 10;
  localparam int AW        = 11;
  localparam int WIN       = 5;
  localparam int MAX_WIDTH = 1920;
  localparam int SW        = 4;
  localparam int RAMW      = DW * SLOTS;

  typedef enum logic {IDLE, RUN} state_e;

  // Active-low write mask: only the DW bits of the selected slot are cleared.
  function automatic logic [RAMW-1:0] slot_mask(input logic [SW-1:0] slot);
    logic [RAMW-1:0] m;
    for (int i = 0; i < RAMW; i++) begin
      m[i] = ((i / DW) != int'(slot));
    end
    return m;
  endfunction

endpackage

// File: rtl/wrap_cnt.sv
// Modulo counter from 0 to limit_i inclusive, with a synchronous clear and a wrap pulse
// asserted in the same cycle as the step that returns the count to zero.
module wrap_cnt #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q, count_d;

  // >= keeps the counter bounded even if the limit shrinks under it.
  assign wrap_o  = en_i && (count_q >= limit_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (wrap_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/median_linebuf_ctrl.sv
// Line-buffer sequencer: accepts disparity pixels, reads the column's stored rows on port B and
// writes the new pixel into its row slot on port A one cycle later, flagging window validity.
module median_linebuf_ctrl
  import median_lb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clken,
  input  logic            enable,
  input  logic [AW-1:0]   width,
  input  logic [10:0]     height,
  input  logic            valid_in,
  input  logic [DW-1:0]   disp_in,
  output logic [AW-1:0]   ram_wr_addr,
  output logic            ram_wr_en_n,
  output logic [RAMW-1:0] ram_bweb,
  output logic [RAMW-1:0] ram_din,
  output logic [AW-1:0]   ram_rd_addr,
  output logic            rd_valid,
  output logic            win_valid,
  output logic [DW-1:0]   disp_out,
  output logic [SW-1:0]   slot_out,
  output logic [AW-1:0]   col_out,
  output logic            frame_done,
  output logic            cfg_err
);

  state_e          state_q;
  logic            cfgOk, accept, clr, colWrap, frameEnd, slotWrap, full_q;
  logic [AW-1:0]   col;
  logic [10:0]     rowUnused;
  logic [SW-1:0]   slot;

  logic            cfgErr_q, s1Valid_q, s1Last_q, s1Win_q;
  logic [DW-1:0]   s1Disp_q;
  logic [AW-1:0]   s1Col_q, rdAddr_q, wrAddr_q, colOut_q;
  logic [SW-1:0]   s1Slot_q, slotOut_q;
  logic            rdValid_q, winValid_q, s2Last_q, done_q, wrEnN_q;
  logic [RAMW-1:0] bweb_q, din_q;
  logic [DW-1:0]   dispOut_q;

  assign cfgOk  = (width >= 11'd2) && (width <= 11'(MAX_WIDTH)) && (height != 11'd0);
  assign accept = clken && (state_q == RUN) && enable && valid_in;
  assign clr    = clken && ((state_q != RUN) || !enable || frameEnd);

  wrap_cnt #(.W(AW)) u_col (
    .clk(clk), .rst(rst), .clr_i(clr), .en_i(accept),
    .limit_i(width - 11'd1), .count_o(col), .wrap_o(colWrap)
  );

  // The row counter only matters for spotting the last row; its wrap is the frame end.
  wrap_cnt #(.W(11)) u_row (
    .clk(clk), .rst(rst), .clr_i(clr), .en_i(colWrap),
    .limit_i(height - 11'd1), .count_o(rowUnused), .wrap_o(frameEnd)
  );

  wrap_cnt #(.W(SW)) u_slot (
    .clk(clk), .rst(rst), .clr_i(clr), .en_i(colWrap),
    .limit_i(SW'(SLOTS - 1)), .count_o(slot), .wrap_o(slotWrap)
  );

  // Until the slot ring first wraps, rows stored so far equals the slot index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      full_q     <= 1'b0;
      cfgErr_q   <= 1'b0;
      s1Valid_q  <= 1'b0;
      s1Last_q   <= 1'b0;
      s1Win_q    <= 1'b0;
      s1Disp_q   <= '0;
      s1Col_q    <= '0;
      s1Slot_q   <= '0;
      rdAddr_q   <= '0;
      rdValid_q  <= 1'b0;
      winValid_q <= 1'b0;
      s2Last_q   <= 1'b0;
      done_q     <= 1'b0;
      wrEnN_q    <= 1'b1;
      wrAddr_q   <= '0;
      bweb_q     <= '1;
      din_q      <= '0;
      dispOut_q  <= '0;
      colOut_q   <= '0;
      slotOut_q  <= '0;
    end else if (clken) begin
      cfgErr_q <= enable && !cfgOk;
      case (state_q)
        IDLE: if (enable && cfgOk) state_q <= RUN;
        RUN:  if (!enable || frameEnd) state_q <= IDLE;
      endcase

      if (clr) begin
        full_q <= 1'b0;
      end else if (slotWrap) begin
        full_q <= 1'b1;
      end

      s1Valid_q <= accept;
      s1Last_q  <= frameEnd;
      if (accept) begin
        rdAddr_q <= col;
        s1Disp_q <= disp_in;
        s1Col_q  <= col;
        s1Slot_q <= slot;
        s1Win_q  <= full_q || (slot >= SW'(WIN - 1));
      end

      // Stage 2 issues the write while the RAM returns the column read in stage 1.
      rdValid_q  <= s1Valid_q;
      wrEnN_q    <= !s1Valid_q;
      winValid_q <= s1Valid_q && s1Win_q;
      s2Last_q   <= s1Valid_q && s1Last_q;
      done_q     <= s2Last_q;
      bweb_q     <= s1Valid_q ? slot_mask(s1Slot_q) : '1;
      if (s1Valid_q) begin
        wrAddr_q  <= s1Col_q;
        din_q     <= {SLOTS{s1Disp_q}};
        dispOut_q <= s1Disp_q;
        colOut_q  <= s1Col_q;
        slotOut_q <= s1Slot_q;
      end
    end
  end

  assign ram_wr_en_n = wrEnN_q || !clken;
  assign rd_valid    = rdValid_q && clken;
  assign win_valid   = winValid_q && clken;
  assign frame_done  = done_q && clken;
  assign ram_wr_addr = wrAddr_q;
  assign ram_bweb    = bweb_q;
  assign ram_din     = din_q;
  assign ram_rd_addr = rdAddr_q;
  assign disp_out    = dispOut_q;
  assign slot_out    = slotOut_q;
  assign col_out     = colOut_q;
  assign cfg_err     = cfgErr_q;

endmodule

// File: tb/tb_median_linebuf_ctrl.sv
// Self-checking bench for median_linebuf_ctrl: table-driven frames, hand-built corner sequences and
// randomized traffic, all checked every cycle against a pixel-index based reference model.
module tb_median_linebuf_ctrl;

  localparam int TB_SLOTS = 10;
  localparam int TB_WIN   = 5;
  localparam int TB_DW    = 9;

  logic        clk = 1'b0;
  logic        rst, clken, enable, valid_in;
  logic [10:0] width, height;
  logic [8:0]  disp_in;
  logic [10:0] ram_wr_addr, ram_rd_addr, col_out;
  logic        ram_wr_en_n, rd_valid, win_valid, frame_done, cfg_err;
  logic [89:0] ram_bweb, ram_din;
  logic [8:0]  disp_out;
  logic [3:0]  slot_out;

  median_linebuf_ctrl dut (
    .clk(clk), .rst(rst), .clken(clken), .enable(enable), .width(width), .height(height),
    .valid_in(valid_in), .disp_in(disp_in), .ram_wr_addr(ram_wr_addr), .ram_wr_en_n(ram_wr_en_n),
    .ram_bweb(ram_bweb), .ram_din(ram_din), .ram_rd_addr(ram_rd_addr), .rd_valid(rd_valid),
    .win_valid(win_valid), .disp_out(disp_out), .slot_out(slot_out), .col_out(col_out),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkOutput(input string name, input logic [89:0] act, input logic [89:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one record per clock-enabled edge, derived from the pixel index in the frame.
  typedef struct {
    bit         acc;
    bit         last;
    int         col;
    int         slot;
    bit         win;
    logic [8:0] disp;
  } rec_t;

  rec_t hist[$];
  bit   mRun, mCfgErr, mLegal;
  int   pixIdx, mRow;
  rec_t r;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      mRun = 0;
      pixIdx = 0;
      mCfgErr = 0;
    end else if (clken) begin
      r.acc = 0; r.last = 0; r.col = 0; r.slot = 0; r.win = 0; r.disp = '0;
      mLegal = (width >= 2) && (width <= 1920) && (height != 0);
      mCfgErr = enable && !mLegal;
      if (!mRun) begin
        if (enable && mLegal) begin
          mRun = 1;
          pixIdx = 0;
        end
      end else if (!enable) begin
        mRun = 0;
      end else if (valid_in) begin
        mRow   = pixIdx / int'(width);
        r.acc  = 1;
        r.col  = pixIdx % int'(width);
        r.slot = mRow % TB_SLOTS;
        r.win  = (((mRow < TB_SLOTS) ? mRow : TB_SLOTS) >= TB_WIN - 1);
        r.disp = disp_in;
        r.last = (pixIdx == int'(width) * int'(height) - 1);
        pixIdx++;
        if (r.last) mRun = 0;
      end
      hist.push_back(r);
    end
  end

  function automatic logic [89:0] expMask(input int slot);
    logic [89:0] m;
    for (int j = 0; j < 90; j++) m[j] = ((j / TB_DW) != slot);
    return m;
  endfunction

  function automatic logic [89:0] expDin(input logic [8:0] d);
    logic [89:0] m;
    for (int j = 0; j < 90; j++) m[j] = d[j % TB_DW];
    return m;
  endfunction

  int rdCount, doneCount, wrCount;
  bit cfgSeen;
  int L;
  bit expRd, expDone;

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) rdCount++;
      if (frame_done) doneCount++;
      if (!ram_wr_en_n) wrCount++;
      if (cfg_err) cfgSeen = 1;
    end
    if (!rst && hist.size() > 0) begin
      L = hist.size() - 1;
      checkOutput("cfg_err", 90'(cfg_err), 90'(mCfgErr));
      if (clken) begin
        expRd = 0;
        expDone = 0;
        if (L >= 1) expRd = hist[L-1].acc;
        if (L >= 2) expDone = hist[L-2].last;
        checkOutput("rd_valid", 90'(rd_valid), 90'(expRd));
        checkOutput("ram_wr_en_n", 90'(ram_wr_en_n), 90'(!expRd));
        checkOutput("frame_done", 90'(frame_done), 90'(expDone));
        if (expRd) begin
          checkOutput("win_valid", 90'(win_valid), 90'(hist[L-1].win));
          checkOutput("disp_out", 90'(disp_out), 90'(hist[L-1].disp));
          checkOutput("col_out", 90'(col_out), 90'(hist[L-1].col));
          checkOutput("slot_out", 90'(slot_out), 90'(hist[L-1].slot));
          checkOutput("ram_wr_addr", 90'(ram_wr_addr), 90'(hist[L-1].col));
          checkOutput("ram_bweb", ram_bweb, expMask(hist[L-1].slot));
          checkOutput("ram_din", ram_din, expDin(hist[L-1].disp));
        end else begin
          checkOutput("win_valid_idle", 90'(win_valid), 90'(0));
        end
        if (hist[L].acc) checkOutput("ram_rd_addr", 90'(ram_rd_addr), 90'(hist[L].col));
      end else begin
        checkOutput("rd_valid_frozen", 90'(rd_valid), 90'(0));
        checkOutput("wr_en_n_frozen", 90'(ram_wr_en_n), 90'(1));
        checkOutput("frame_done_frozen", 90'(frame_done), 90'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCounts();
    rdCount = 0; doneCount = 0; wrCount = 0; cfgSeen = 0;
  endtask

  task automatic applyStimulus(input int w, input int h, input int gap, input int n);
    width = 11'(w);
    height = 11'(h);
    enable = 1;
    valid_in = 0;
    tick();
    for (int i = 0; i < n; i++) begin
      valid_in = 1;
      disp_in = 9'($urandom);
      tick();
      valid_in = 0;
      repeat (gap) tick();
    end
    valid_in = 0;
    enable = 0;
    repeat (5) tick();
  endtask

  typedef struct {
    int w;
    int h;
    int gap;
    int expErr;
    int expRd;
    int expDone;
  } vec_t;

  vec_t vecs[9];

  initial begin
    rst = 1; clken = 1; enable = 0; valid_in = 0; disp_in = '0; width = 11'd4; height = 11'd3;
    clearCounts();

    vecs[0] = '{4, 3, 0, 0, 12, 1};
    vecs[1] = '{4, 6, 0, 0, 24, 1};
    vecs[2] = '{3, 12, 0, 0, 36, 1};
    vecs[3] = '{5, 2, 2, 0, 10, 1};
    vecs[4] = '{1, 3, 0, 1, 0, 0};
    vecs[5] = '{1921, 1, 0, 1, 0, 0};
    vecs[6] = '{8, 0, 0, 1, 0, 0};
    vecs[7] = '{2, 1, 0, 0, 2, 1};
    vecs[8] = '{7, 3, 1, 0, 21, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wr_en_n", 90'(ram_wr_en_n), 90'(1));
    checkOutput("rst_bweb", ram_bweb, {90{1'b1}});
    checkOutput("rst_wr_addr", 90'(ram_wr_addr), 90'(0));
    checkOutput("rst_rd_addr", 90'(ram_rd_addr), 90'(0));
    checkOutput("rst_din", ram_din, 90'(0));
    checkOutput("rst_rd_valid", 90'(rd_valid), 90'(0));
    checkOutput("rst_win_valid", 90'(win_valid), 90'(0));
    checkOutput("rst_frame_done", 90'(frame_done), 90'(0));
    checkOutput("rst_cfg_err", 90'(cfg_err), 90'(0));
    checkOutput("rst_disp_out", 90'(disp_out), 90'(0));
    checkOutput("rst_slot_out", 90'(slot_out), 90'(0));
    checkOutput("rst_col_out", 90'(col_out), 90'(0));
    @(posedge clk);
    #1 rst = 0;
    tick();

    for (int i = 0; i < 9; i++) begin
      clearCounts();
      applyStimulus(vecs[i].w, vecs[i].h, vecs[i].gap,
                    (vecs[i].expErr != 0) ? 4 : vecs[i].w * vecs[i].h);
      checkOutput("tbl_rd_count", 90'(rdCount), 90'(vecs[i].expRd));
      checkOutput("tbl_wr_count", 90'(wrCount), 90'(vecs[i].expRd));
      checkOutput("tbl_done_count", 90'(doneCount), 90'(vecs[i].expDone));
      checkOutput("tbl_cfg_err", 90'(cfgSeen), 90'(vecs[i].expErr));
    end

    // Abort at row 1 col 2, then confirm the next frame restarts at column 0, slot 0.
    clearCounts();
    width = 11'd4; height = 11'd3; enable = 1;
    tick();
    for (int i = 0; i < 7; i++) begin
      valid_in = 1; disp_in = 9'(i + 1); tick();
    end
    valid_in = 0; enable = 0;
    repeat (5) tick();
    checkOutput("abort_rd_count", 90'(rdCount), 90'(7));
    checkOutput("abort_wr_count", 90'(wrCount), 90'(7));
    checkOutput("abort_done_count", 90'(doneCount), 90'(0));
    enable = 1;
    tick();
    valid_in = 1; disp_in = 9'h155; tick();
    valid_in = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_valid) break;
    end
    checkOutput("restart_rd_valid", 90'(rd_valid), 90'(1));
    checkOutput("restart_col", 90'(col_out), 90'(0));
    checkOutput("restart_slot", 90'(slot_out), 90'(0));
    checkOutput("restart_wr_addr", 90'(ram_wr_addr), 90'(0));
    @(posedge clk); #1;
    enable = 0;
    repeat (5) tick();

    // Freeze clken for three cycles mid-row with valid_in held high.
    clearCounts();
    width = 11'd6; height = 11'd2; enable = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      valid_in = 1; disp_in = 9'(20 + i); tick();
    end
    clken = 0; disp_in = 9'h1ff;
    repeat (3) tick();
    clken = 1;
    for (int i = 3; i < 12; i++) begin
      valid_in = 1; disp_in = 9'(20 + i); tick();
    end
    valid_in = 0; enable = 0;
    repeat (5) tick();
    checkOutput("freeze_rd_count", 90'(rdCount), 90'(12));
    checkOutput("freeze_done_count", 90'(doneCount), 90'(1));

    // Randomized traffic: gaps, clken stalls, occasional aborts and illegal configurations.
    for (int f = 0; f < 30; f++) begin
      enable = 0; clken = 1; valid_in = 0;
      repeat (4) tick();
      width = 11'($urandom_range(2, 10));
      height = 11'($urandom_range(1, 6));
      if (f % 7 == 6) width = 11'd1;
      if (f % 11 == 10) height = 11'd0;
      for (int c = 0; c < 80; c++) begin
        enable = ($urandom_range(0, 99) != 0);
        clken = ($urandom_range(0, 7) != 0);
        valid_in = ($urandom_range(0, 3) != 0);
        disp_in = 9'($urandom);
        tick();
      end
    end
    enable = 0; clken = 1; valid_in = 0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
